// File: rtl/demux_fifo_2ch.sv
// demux_fifo_2ch: de-interleaves a valid byte stream into two lanes, each buffered by a DEPTH-entry FIFO.
// Optional almost_full_0/1 outputs are enabled by defining DEMUX_ALMOST_FULL_EN.
module demux_fifo_2ch #(
    parameter int DATA_W = 8,
    parameter int DEPTH  = 4,
    parameter int ADDR_W = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [DATA_W-1:0] data_in,
    input  logic              valid_in,
    input  logic              pop_0,
    input  logic              pop_1,
    output logic [DATA_W-1:0] data_out_0,
    output logic              valid_out_0,
    output logic [DATA_W-1:0] data_out_1,
    output logic              valid_out_1,
    output logic              empty_0,
    output logic              empty_1,
    output logic              full_0,
    output logic              full_1,
    output logic              overflow_0,
    output logic              overflow_1
`ifdef DEMUX_ALMOST_FULL_EN
    ,
    output logic              almost_full_0,
    output logic              almost_full_1
`endif
);
    logic       sel;
    logic [1:0] pop;

    assign pop = {pop_1, pop_0};

    // sel toggles on every valid byte, even a dropped one, to stay aligned with the mux
    always_ff @(posedge clk) begin
        if (reset) sel <= 1'b0;
        else if (valid_in) sel <= ~sel;
    end

    for (genvar i = 0; i < 2; i++) begin : g_lane
        logic [DATA_W-1:0] mem [DEPTH];
        logic [ADDR_W-1:0] wr, rd;
        logic [ADDR_W:0]   cnt, cnt_nxt;
        logic [DATA_W-1:0] dout;
        logic              vout, full, empty, ovf, push, do_push, do_pop;
`ifdef DEMUX_ALMOST_FULL_EN
        logic              af;
`endif
        assign push    = valid_in && (sel == 1'(i));
        assign do_pop  = pop[i] && !empty;
        assign do_push = push && (!full || pop[i]);
        assign cnt_nxt = cnt + {{ADDR_W{1'b0}}, do_push} - {{ADDR_W{1'b0}}, do_pop};
        always_ff @(posedge clk) begin
            if (reset) begin
                wr    <= '0;
                rd    <= '0;
                cnt   <= '0;
                dout  <= '0;
                vout  <= 1'b0;
                full  <= 1'b0;
                empty <= 1'b1;
                ovf   <= 1'b0;
`ifdef DEMUX_ALMOST_FULL_EN
                af    <= 1'b0;
`endif
            end else begin
                if (do_push) begin
                    mem[wr] <= data_in;
                    wr      <= wr + 1'b1;
                end
                if (do_pop) begin
                    dout <= mem[rd];
                    rd   <= rd + 1'b1;
                end
                if (push && !do_push) ovf <= 1'b1;
                vout  <= do_pop;
                cnt   <= cnt_nxt;
                full  <= cnt_nxt == (ADDR_W+1)'(DEPTH);
                empty <= cnt_nxt == '0;
`ifdef DEMUX_ALMOST_FULL_EN
                af    <= cnt_nxt >= (ADDR_W+1)'(DEPTH-1);
`endif
            end
        end
    end

    assign data_out_0  = g_lane[0].dout;
    assign valid_out_0 = g_lane[0].vout;
    assign empty_0     = g_lane[0].empty;
    assign full_0      = g_lane[0].full;
    assign overflow_0  = g_lane[0].ovf;
    assign data_out_1  = g_lane[1].dout;
    assign valid_out_1 = g_lane[1].vout;
    assign empty_1     = g_lane[1].empty;
    assign full_1      = g_lane[1].full;
    assign overflow_1  = g_lane[1].ovf;
`ifdef DEMUX_ALMOST_FULL_EN
    assign almost_full_0 = g_lane[0].af;
    assign almost_full_1 = g_lane[1].af;
`endif
endmodule

// File: tb/tb_demux_fifo_2ch.sv
// tb_demux_fifo_2ch: directed and random stimulus with a per-lane expected-byte scoreboard.
module tb_demux_fifo_2ch;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] data_in = '0;
    logic       valid_in = 1'b0, pop_0 = 1'b0, pop_1 = 1'b0;
    logic [7:0] data_out_0, data_out_1;
    logic       valid_out_0, valid_out_1, empty_0, empty_1, full_0, full_1, overflow_0, overflow_1;
`ifdef DEMUX_ALMOST_FULL_EN
    logic       almost_full_0, almost_full_1;
`endif

    int         n_chk = 0;
    int         n_fail = 0;
    logic [7:0] q0[$], q1[$];
    logic       msel, mov0, mov1, ev0, ev1;
    logic [7:0] mdo0, mdo1;

    demux_fifo_2ch dut (
        .clk(clk), .reset(reset), .data_in(data_in), .valid_in(valid_in),
        .pop_0(pop_0), .pop_1(pop_1),
        .data_out_0(data_out_0), .valid_out_0(valid_out_0),
        .data_out_1(data_out_1), .valid_out_1(valid_out_1),
        .empty_0(empty_0), .empty_1(empty_1), .full_0(full_0), .full_1(full_1),
        .overflow_0(overflow_0), .overflow_1(overflow_1)
`ifdef DEMUX_ALMOST_FULL_EN
        , .almost_full_0(almost_full_0), .almost_full_1(almost_full_1)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, " valid_out_0"}, 32'(valid_out_0), 32'(ev0));
        chk({tag, " valid_out_1"}, 32'(valid_out_1), 32'(ev1));
        chk({tag, " data_out_0"}, 32'(data_out_0), 32'(mdo0));
        chk({tag, " data_out_1"}, 32'(data_out_1), 32'(mdo1));
        chk({tag, " empty_0"}, 32'(empty_0), 32'(q0.size() == 0));
        chk({tag, " empty_1"}, 32'(empty_1), 32'(q1.size() == 0));
        chk({tag, " full_0"}, 32'(full_0), 32'(q0.size() == 4));
        chk({tag, " full_1"}, 32'(full_1), 32'(q1.size() == 4));
        chk({tag, " overflow_0"}, 32'(overflow_0), 32'(mov0));
        chk({tag, " overflow_1"}, 32'(overflow_1), 32'(mov1));
`ifdef DEMUX_ALMOST_FULL_EN
        chk({tag, " almost_full_0"}, 32'(almost_full_0), 32'(q0.size() >= 3));
        chk({tag, " almost_full_1"}, 32'(almost_full_1), 32'(q1.size() >= 3));
`endif
    endtask

    task automatic do_reset(input string tag);
        reset = 1'b1; valid_in = 1'b0; pop_0 = 1'b0; pop_1 = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        q0.delete(); q1.delete();
        msel = 1'b0; mov0 = 1'b0; mov1 = 1'b0; mdo0 = '0; mdo1 = '0; ev0 = 1'b0; ev1 = 1'b0;
        check_all(tag);
    endtask

    // one clock: drive, update the model (pops use pre-push occupancy), then check
    task automatic cyc(input string tag, input logic v, input logic [7:0] d, input logic p0, input logic p1);
        valid_in = v; data_in = d; pop_0 = p0; pop_1 = p1;
        ev0 = p0 && q0.size() > 0;
        ev1 = p1 && q1.size() > 0;
        if (ev0) mdo0 = q0.pop_front();
        if (ev1) mdo1 = q1.pop_front();
        if (v) begin
            if (!msel) begin
                if (q0.size() < 4) q0.push_back(d); else mov0 = 1'b1;
            end else begin
                if (q1.size() < 4) q1.push_back(d); else mov1 = 1'b1;
            end
            msel = ~msel;
        end
        @(posedge clk); #1;
        valid_in = 1'b0; pop_0 = 1'b0; pop_1 = 1'b0;
        check_all(tag);
    endtask

    initial begin
        do_reset("t1_reset");
        cyc("t1_a1", 1, 8'hA1, 0, 0);
        cyc("t1_b1", 1, 8'hB1, 0, 0);
        cyc("t1_a2", 1, 8'hA2, 0, 0);
        cyc("t1_b2", 1, 8'hB2, 0, 0);
        cyc("t1_pop0a", 0, 8'h00, 1, 0);
        chk("t1_first_byte", 32'(data_out_0), 32'hA1);
        cyc("t1_pop0b", 0, 8'h00, 1, 0);
        chk("t1_second_byte", 32'(data_out_0), 32'hA2);
        cyc("t1_pop1", 0, 8'h00, 0, 1);
        cyc("t1_pop0_empty", 0, 8'h00, 1, 1);

        do_reset("t2_reset");
        for (int i = 0; i < 10; i++) cyc("t2_fill", 1, 8'(i[3:1] + (i[0] ? 8'h20 : 8'h10)), 0, 0);
        chk("t2_overflow_0", 32'(overflow_0), 32'h1);
        for (int i = 0; i < 5; i++) cyc("t2_drain", 0, 8'h00, 1, 1);

        do_reset("t3_reset");
        for (int i = 0; i < 8; i++) cyc("t3_fill", 1, 8'(8'h30 + i), 0, 0);
        cyc("t3_push_pop_full", 1, 8'h3F, 1, 0);
        chk("t3_no_overflow", 32'(overflow_0), 32'h0);
        for (int i = 0; i < 5; i++) cyc("t3_drain", 0, 8'h00, 1, 0);

        do_reset("t4_reset");
        cyc("t4_push_pop_empty", 1, 8'h55, 1, 0);
        chk("t4_no_fallthrough", 32'(valid_out_0), 32'h0);
        cyc("t4_pop", 0, 8'h00, 1, 0);

        do_reset("t5_reset");
        for (int i = 0; i < 9; i++) cyc("t5_fill", 1, 8'(8'h60 + i), 0, 0);
        do_reset("t5_reset_mid");
        cyc("t5_after", 1, 8'h77, 0, 0);
        cyc("t5_pop", 0, 8'h00, 1, 1);

`ifdef DEMUX_ALMOST_FULL_EN
        do_reset("t6_reset");
        for (int i = 0; i < 6; i++) cyc("t6_fill", 1, 8'(8'h80 + i), 0, 0);
        chk("t6_af1_set", 32'(almost_full_1), 32'h1);
        cyc("t6_pop1", 0, 8'h00, 0, 1);
        chk("t6_af1_clear", 32'(almost_full_1), 32'h0);
`endif

        do_reset("rnd_reset");
        for (int i = 0; i < 300; i++)
            cyc("rnd", 1'($urandom_range(0, 3) != 0), 8'($urandom), 1'($urandom_range(0, 2) == 0),
                1'($urandom_range(0, 2) == 0));
        for (int i = 0; i < 5; i++) cyc("rnd_drain", 0, 8'h00, 1, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
